// File: rtl/sb_hfosc_if.sv
// Control and status bundle of the high-frequency oscillator model.
// master drives CLKHFPU/CLKHFEN and observes outputs; slave is the oscillator.
interface sb_hfosc_if;
    logic CLKHFPU;
    logic CLKHFEN;
    logic CLKHF;
    logic CLKHF_RDY;
    logic CLKHF_TICK;

    modport master (
        output CLKHFPU,
        output CLKHFEN,
        input  CLKHF,
        input  CLKHF_RDY,
        input  CLKHF_TICK
    );

    modport slave (
        input  CLKHFPU,
        input  CLKHFEN,
        output CLKHF,
        output CLKHF_RDY,
        output CLKHF_TICK
    );
endinterface

// File: rtl/sb_hfosc.sv
// Synchronous model of a power-gated HF oscillator: settle, then divide clk.
// Ports: clk, reset (sync, active-high), osc (slave: CLKHFPU/EN in, CLKHF/RDY/TICK out).
module sb_hfosc #(
    parameter logic [1:0]  CLKHF_DIV = 2'b00,
    parameter int unsigned PU_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    sb_hfosc_if.slave      osc
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_POWERUP,
        ST_READY
    } state_t;

    // Last divider count before CLKHF flips: half period minus one.
    localparam logic [2:0] DIV_LAST    = 3'((1 << CLKHF_DIV) - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(PU_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] settle, settle_n;
    logic [2:0] div, div_n;
    logic       clkhf, clkhf_n;
    logic       rdy, rdy_n;
    logic       tick, tick_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_OFF;
            settle <= '0;
            div    <= '0;
            clkhf  <= 1'b0;
            rdy    <= 1'b0;
            tick   <= 1'b0;
        end else begin
            state  <= state_n;
            settle <= settle_n;
            div    <= div_n;
            clkhf  <= clkhf_n;
            rdy    <= rdy_n;
            tick   <= tick_n;
        end
    end

    always_comb begin
        state_n  = state;
        settle_n = settle;
        div_n    = div;
        clkhf_n  = clkhf;
        rdy_n    = rdy;
        tick_n   = 1'b0;

        // Power-down dominates everything, including a pending divider wrap.
        if (!osc.CLKHFPU) begin
            state_n  = ST_OFF;
            settle_n = '0;
            div_n    = '0;
            clkhf_n  = 1'b0;
            rdy_n    = 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_n  = ST_POWERUP;
                    settle_n = '0;
                    div_n    = '0;
                    clkhf_n  = 1'b0;
                    rdy_n    = 1'b0;
                end
                ST_POWERUP: begin
                    clkhf_n = 1'b0;
                    div_n   = '0;
                    if (settle == SETTLE_LAST) begin
                        state_n = ST_READY;
                        rdy_n   = 1'b1;
                    end else begin
                        settle_n = settle + 8'd1;
                    end
                end
                ST_READY: begin
                    rdy_n = 1'b1;
                    if (osc.CLKHFEN) begin
                        if (div == DIV_LAST) begin
                            div_n   = '0;
                            clkhf_n = ~clkhf;
                            // Tick only on the low-to-high flip.
                            tick_n  = ~clkhf;
                        end else begin
                            div_n = div + 3'd1;
                        end
                    end else begin
                        // Disabling parks the output low and rewinds the
                        // divider so re-enable starts a full low half.
                        div_n   = '0;
                        clkhf_n = 1'b0;
                    end
                end
                default: begin
                    state_n  = ST_OFF;
                    settle_n = '0;
                    div_n    = '0;
                    clkhf_n  = 1'b0;
                    rdy_n    = 1'b0;
                end
            endcase
        end
    end

    assign osc.CLKHF      = clkhf;
    assign osc.CLKHF_RDY  = rdy;
    assign osc.CLKHF_TICK = tick;

endmodule

// File: tb/tb_sb_hfosc.sv
// Self-checking bench for sb_hfosc: directed table, corner sequences, random.
// Two instances (divide 1 and divide 4) share the same stimulus.
module tb_sb_hfosc;

    localparam int PU = 16;
    localparam int H0 = 1;
    localparam int H2 = 4;

    bit clk = 1'b0;
    bit rst = 1'b1;
    always #5 clk = ~clk;

    sb_hfosc_if ifa();
    sb_hfosc_if ifb();

    sb_hfosc #(.CLKHF_DIV(2'b00), .PU_CYCLES(PU)) dut0 (
        .clk   (clk),
        .reset (rst),
        .osc   (ifa)
    );

    sb_hfosc #(.CLKHF_DIV(2'b10), .PU_CYCLES(PU)) dut2 (
        .clk   (clk),
        .reset (rst),
        .osc   (ifb)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: counts of qualifying edges, outputs derived by arithmetic.
    int pu_edges = 0;
    int en_run   = 0;
    bit m_rdy    = 1'b0;

    function automatic bit exp_clk(input int h);
        return ((en_run / h) % 2) == 1;
    endfunction

    function automatic bit exp_tick(input int h);
        return (en_run > 0) && ((en_run % (2 * h)) == h);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit pu, input bit en);
        rst = r;
        ifa.CLKHFPU = pu;
        ifb.CLKHFPU = pu;
        ifa.CLKHFEN = en;
        ifb.CLKHFEN = en;
        @(posedge clk);
        if (r || !pu) begin
            pu_edges = 0;
            en_run   = 0;
            m_rdy    = 1'b0;
        end else begin
            pu_edges++;
            if (m_rdy && en) en_run++;
            else en_run = 0;
            m_rdy = (pu_edges >= PU + 1);
        end
        #1;
        chk("m0_clk",  int'(ifa.CLKHF),      int'(exp_clk(H0)));
        chk("m0_tick", int'(ifa.CLKHF_TICK), int'(exp_tick(H0)));
        chk("m0_rdy",  int'(ifa.CLKHF_RDY),  int'(m_rdy));
        chk("m2_clk",  int'(ifb.CLKHF),      int'(exp_clk(H2)));
        chk("m2_tick", int'(ifb.CLKHF_TICK), int'(exp_tick(H2)));
        chk("m2_rdy",  int'(ifb.CLKHF_RDY),  int'(m_rdy));
    endtask

    typedef struct {
        bit r;
        bit pu;
        bit en;
        bit clk;
        bit rdy;
        bit tick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit pu, bit en, bit c, bit rd, bit t);
        vec_t v;
        v.r = r; v.pu = pu; v.en = en;
        v.clk = c; v.rdy = rd; v.tick = t;
        return v;
    endfunction

    initial begin
        int n;
        int hi;
        int tk;
        bit seen;
        bit any;

        ifa.CLKHFPU = 1'b0; ifa.CLKHFEN = 1'b0;
        ifb.CLKHFPU = 1'b0; ifb.CLKHFEN = 1'b0;

        // Hand-derived expectations for the divide-by-1 instance.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0));
        for (int k = 1; k <= 16; k++) tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, 1, ~k[0], 1, ~k[0]));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].pu, tbl[i].en);
            chk("tbl_clk",  int'(ifa.CLKHF),      int'(tbl[i].clk));
            chk("tbl_rdy",  int'(ifa.CLKHF_RDY),  int'(tbl[i].rdy));
            chk("tbl_tick", int'(ifa.CLKHF_TICK), int'(tbl[i].tick));
        end

        // Divide-by-4: 16 steady cycles hold 8 high cycles and 2 ticks.
        hi = 0; tk = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1);
            hi += int'(ifb.CLKHF);
            tk += int'(ifb.CLKHF_TICK);
        end
        chk("div4_high", hi, 8);
        chk("div4_ticks", tk, 2);

        // Drop enable while high, then re-enable.
        n = 0;
        while (!ifa.CLKHF && n < 4) begin
            step(0, 1, 1);
            n++;
        end
        chk("wait_high", int'(ifa.CLKHF), 1);
        step(0, 1, 0);
        chk("dis_clk", int'(ifa.CLKHF), 0);
        chk("dis_rdy", int'(ifa.CLKHF_RDY), 1);
        step(0, 1, 1);
        chk("reen_clk0", int'(ifa.CLKHF), 1);
        n = 1;
        while (!ifb.CLKHF && n < 20) begin
            step(0, 1, 1);
            n++;
        end
        chk("reen_rise2", n, 4);

        // Power-up glitch at cycle 10 earns no settling credit.
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1);
        step(0, 0, 1);
        chk("glitch_rdy", int'(ifa.CLKHF_RDY), 0);
        n = 0;
        do begin
            step(0, 1, 1);
            n++;
        end while (!ifa.CLKHF_RDY && n < 40);
        chk("glitch_settle", n, 17);

        // Reset while toggling.
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        step(1, 1, 1);
        chk("rst_clk", int'(ifa.CLKHF) | int'(ifb.CLKHF), 0);
        chk("rst_rdy", int'(ifa.CLKHF_RDY), 0);
        n = 0; seen = 1'b0;
        do begin
            step(0, 1, 1);
            n++;
            if (ifa.CLKHF || ifb.CLKHF) seen = 1'b1;
        end while (!ifa.CLKHF_RDY && n < 40);
        chk("rst_settle", n, 17);
        chk("rst_no_toggle", int'(seen), 0);

        // Powered down with enable high stays silent.
        any = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1);
            any |= ifa.CLKHF | ifa.CLKHF_RDY | ifa.CLKHF_TICK;
            any |= ifb.CLKHF | ifb.CLKHF_RDY | ifb.CLKHF_TICK;
        end
        chk("off_silent", int'(any), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, pu, en;
            r  = ($urandom_range(0, 199) == 0);
            pu = ($urandom_range(0, 59) != 0);
            en = ($urandom_range(0, 9) != 0);
            step(r, pu, en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
